// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state codes, ACK/NACK bit levels and the
// byte-count width helper used by the master's BYTE_NUM port.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    BIT   = 4'd2,
    ACK   = 4'd3,
    STOP  = 4'd4,
    DONE  = 4'd5,
    REARM = 4'd6
  } i2c_state_e;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

  // Bits needed to hold a byte count in 0..max_bytes
  function automatic int unsigned byte_cnt_width(input int unsigned max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-phase tick generator. Emits a one-clock tick every CLK_DIV clocks
// while enabled; the count restarts from zero whenever disabled.
// Build option: I2C_CLK_STRETCH_EN freezes the count while the master
// releases SCL but a slave still holds it low.
module i2c_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic PT_CK,
  input  logic RESET_N,
  input  logic en,
  input  logic scl_drive,
  input  logic scl_sense,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          frozen;

`ifdef I2C_CLK_STRETCH_EN
  assign frozen = scl_drive & ~scl_sense;
`else
  logic unused_stretch;
  assign unused_stretch = scl_drive ^ scl_sense;
  assign frozen = 1'b0;
`endif

  assign tick = en & ~frozen & (cnt_q == LAST);

  // Free-running quarter-phase counter, held while stretched
  always_ff @(posedge PT_CK) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else if (!en) begin
      cnt_q <= '0;
    end else if (!frozen) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_rw.sv
// I2C read/write master. One transaction per GO request: START, address
// byte {SLAVE_ADDRESS, RW}, up to MAX_BYTES data bytes, STOP. Each SCL bit
// is four quarter-phases: q0 SCL low + SDA update, q1 SCL low, q2 SCL high
// + SDA sample (taken at the end of q2), q3 SCL high.
// Build option: I2C_CLK_STRETCH_EN enables slave clock stretching.
module i2c_master_rw
  import i2c_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic                                  PT_CK,
  input  logic                                  RESET_N,
  input  logic                                  GO,
  input  logic                                  RW,
  input  logic [6:0]                            SLAVE_ADDRESS,
  input  logic [byte_cnt_width(MAX_BYTES)-1:0]  BYTE_NUM,
  input  logic [8*MAX_BYTES-1:0]                WR_DATA,
  output logic [8*MAX_BYTES-1:0]                RD_DATA,
  input  logic                                  SDAI,
  output logic                                  SDAO,
  input  logic                                  SCLI,
  output logic                                  SCLO,
  output logic                                  END_OK,
  output logic                                  ACK_OK,
  output logic                                  NACK_ERR,
  output logic [3:0]                            ST
);

  localparam int unsigned BW = byte_cnt_width(MAX_BYTES);

  i2c_state_e           state_q;
  logic [1:0]           q_q;
  logic [2:0]           bit_cnt_q;
  logic [BW-1:0]        byte_idx_q;
  logic [BW-1:0]        n_bytes_q;
  logic                 rw_q;
  logic                 addr_frame_q;
  logic [7:0]           tx_byte_q;
  logic [8*MAX_BYTES-1:0] wr_q;
  logic                 nack_q;
  logic                 sdao_q;
  logic                 sclo_q;
  logic                 end_ok_q;
  logic                 ack_ok_q;
  logic                 nack_err_q;
  logic [8*MAX_BYTES-1:0] rd_q;

  logic                 tick;
  logic                 busy;
  logic                 rd_phase;
  logic                 last_byte;
  logic [BW-1:0]        n_clamped;
  logic [BW-1:0]        nxt_idx;
  logic [7:0]           wr_byte;
  logic [8*MAX_BYTES-1:0] rd_next;

  assign busy      = (state_q == START) || (state_q == BIT) ||
                     (state_q == ACK) || (state_q == STOP);
  // Data bits of a read transaction are driven by the slave
  assign rd_phase  = rw_q & ~addr_frame_q;
  assign last_byte = (byte_idx_q == n_bytes_q - BW'(1));
  assign n_clamped = (BYTE_NUM > BW'(MAX_BYTES)) ? BW'(MAX_BYTES) : BYTE_NUM;
  assign nxt_idx   = addr_frame_q ? '0 : byte_idx_q + BW'(1);

  i2c_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .PT_CK     (PT_CK),
    .RESET_N   (RESET_N),
    .en        (busy),
    .scl_drive (sclo_q),
    .scl_sense (SCLI),
    .tick      (tick)
  );

  // Select the next write byte; byte 0 sits in the MSBs
  always_comb begin
    wr_byte = '0;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (nxt_idx == BW'(i)) wr_byte = wr_q[8*(int'(MAX_BYTES)-1-i) +: 8];
    end
  end

  // Read data with the current SDAI bit merged at the current byte/bit slot
  always_comb begin
    rd_next = rd_q;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (byte_idx_q == BW'(i)) rd_next[8*(int'(MAX_BYTES)-1-i) + int'(bit_cnt_q)] = SDAI;
    end
  end

  // Transaction FSM with registered line drives and status
  always_ff @(posedge PT_CK) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      q_q          <= 2'd0;
      bit_cnt_q    <= 3'd0;
      byte_idx_q   <= '0;
      n_bytes_q    <= '0;
      rw_q         <= 1'b0;
      addr_frame_q <= 1'b0;
      tx_byte_q    <= 8'h00;
      wr_q         <= '0;
      nack_q       <= 1'b0;
      sdao_q       <= 1'b1;
      sclo_q       <= 1'b1;
      end_ok_q     <= 1'b1;
      ack_ok_q     <= 1'b0;
      nack_err_q   <= 1'b0;
      rd_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (GO) begin
            rw_q         <= RW;
            tx_byte_q    <= {SLAVE_ADDRESS, RW};
            n_bytes_q    <= n_clamped;
            wr_q         <= WR_DATA;
            ack_ok_q     <= 1'b0;
            nack_err_q   <= 1'b0;
            end_ok_q     <= 1'b0;
            addr_frame_q <= 1'b1;
            byte_idx_q   <= '0;
            q_q          <= 2'd0;
            sdao_q       <= 1'b1;
            sclo_q       <= 1'b1;
            state_q      <= START;
          end
        end
        START: begin
          if (tick) begin
            if (q_q == 2'd0) begin
              sdao_q <= 1'b0;
              q_q    <= 2'd1;
            end else begin
              state_q   <= BIT;
              q_q       <= 2'd0;
              sclo_q    <= 1'b0;
              sdao_q    <= tx_byte_q[7];
              bit_cnt_q <= 3'd7;
            end
          end
        end
        BIT: begin
          if (tick) begin
            unique case (q_q)
              2'd0: q_q <= 2'd1;
              2'd1: begin
                q_q    <= 2'd2;
                sclo_q <= 1'b1;
              end
              2'd2: begin
                q_q <= 2'd3;
                if (rd_phase) rd_q <= rd_next;
              end
              2'd3: begin
                q_q    <= 2'd0;
                sclo_q <= 1'b0;
                if (bit_cnt_q != 3'd0) begin
                  bit_cnt_q <= bit_cnt_q - 3'd1;
                  sdao_q    <= rd_phase ? 1'b1 : tx_byte_q[bit_cnt_q - 3'd1];
                end else begin
                  state_q <= ACK;
                  // Master acknowledges read bytes, NACKing the last one
                  sdao_q  <= rd_phase ? (last_byte ? NACK_BIT : ACK_BIT) : 1'b1;
                end
              end
            endcase
          end
        end
        ACK: begin
          if (tick) begin
            unique case (q_q)
              2'd0: q_q <= 2'd1;
              2'd1: begin
                q_q    <= 2'd2;
                sclo_q <= 1'b1;
              end
              2'd2: begin
                q_q    <= 2'd3;
                nack_q <= SDAI;
              end
              2'd3: begin
                q_q    <= 2'd0;
                sclo_q <= 1'b0;
                if (!rd_phase && (nack_q == NACK_BIT)) begin
                  nack_err_q <= 1'b1;
                  state_q    <= STOP;
                  sdao_q     <= 1'b0;
                end else if (addr_frame_q ? (n_bytes_q == '0) : last_byte) begin
                  state_q <= STOP;
                  sdao_q  <= 1'b0;
                end else begin
                  state_q      <= BIT;
                  addr_frame_q <= 1'b0;
                  byte_idx_q   <= nxt_idx;
                  tx_byte_q    <= wr_byte;
                  bit_cnt_q    <= 3'd7;
                  sdao_q       <= rw_q ? 1'b1 : wr_byte[7];
                end
              end
            endcase
          end
        end
        STOP: begin
          if (tick) begin
            unique case (q_q)
              2'd0: begin
                q_q    <= 2'd1;
                sclo_q <= 1'b1;
              end
              2'd1: begin
                q_q    <= 2'd2;
                sdao_q <= 1'b1;
              end
              default: begin
                q_q     <= 2'd0;
                state_q <= DONE;
              end
            endcase
          end
        end
        DONE: begin
          end_ok_q <= 1'b1;
          ack_ok_q <= ~nack_err_q;
          state_q  <= REARM;
        end
        REARM: begin
          // Wait for GO to drop so a held request cannot retrigger
          if (!GO) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SDAO     = sdao_q;
  assign SCLO     = sclo_q;
  assign END_OK   = end_ok_q;
  assign ACK_OK   = ack_ok_q;
  assign NACK_ERR = nack_err_q;
  assign RD_DATA  = rd_q;
  assign ST       = state_q;

endmodule

// File: doc/i2c_master_rw.md
I2C_MASTER_RW -- requirements
Module: i2c_master_rw

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 4, giving the maximum number of data bytes per transaction (1..16).
REQ-002 SHALL have parameter CLK_DIV, default 4, giving the number of PT_CK cycles per SCL quarter-period (>=1).
REQ-003 SHALL have port PT_CK  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N  in  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port GO  in  1  level transaction request.
REQ-006 SHALL have port RW  in  1  0=write, 1=read; sampled at start.
REQ-007 SHALL have port SLAVE_ADDRESS  in  7  7-bit slave address; sampled at start.
REQ-008 SHALL have port BYTE_NUM  in  $clog2(MAX_BYTES+1)  number of data bytes; sampled at start.
REQ-009 SHALL have port WR_DATA  in  8*MAX_BYTES  write bytes; byte 0 occupies the MSBs and is sent first.
REQ-010 SHALL have port RD_DATA  out  8*MAX_BYTES  read bytes; byte 0 is in the MSBs.
REQ-011 SHALL have port SDAI  in  1  SDA line sense.
REQ-012 SHALL have port SDAO  out  1  SDA drive; 1 releases the line.
REQ-013 SHALL have port SCLI  in  1  SCL line sense.
REQ-014 SHALL have port SCLO  out  1  SCL drive; 1 releases the line.
REQ-015 SHALL have port END_OK  out  1  1 when idle or the transaction is complete.
REQ-016 SHALL have port ACK_OK  out  1  1 when every slave ACK in the last transaction was received.
REQ-017 SHALL have port NACK_ERR  out  1  1 when the last transaction aborted on a slave NACK.
REQ-018 SHALL have port ST  out  4  current state code, for debug.

Function
REQ-019 SHALL use states IDLE, START, BIT, ACK, STOP, DONE and REARM.
- Each SCL bit period is 4 quarter-phases of CLK_DIV clocks each.
- q0: SCLO=0 and SDA is updated.
- q1: SCLO=0.
- q2: SCLO=1 and SDA is sampled.
- q3: SCLO=1.
REQ-020 SHALL accept a request when GO=1 in IDLE:
- latch RW, SLAVE_ADDRESS, BYTE_NUM and WR_DATA;
- clear ACK_OK and NACK_ERR;
- drive END_OK=0 on the next edge.
REQ-021 SHALL generate START as SDA 1->0 while SCL=1, held for one quarter-phase, followed by SCL low.
REQ-022 SHALL send the address byte {SLAVE_ADDRESS, RW} MSB-first, then release SDA for the ACK bit.
REQ-023 SHALL treat SDAI=0 at ACK-bit q2 as ACK and SDAI=1 as NACK.
REQ-024 SHALL, on any NACK, skip the remaining bytes, go to STOP, and set NACK_ERR=1 and ACK_OK=0.
REQ-025 SHALL, in write mode, send BYTE_NUM bytes from WR_DATA, sampling the ACK after each byte.
REQ-026 SHALL, in read mode:
- release SDA (SDAO=1) for data bits;
- shift SDAI into RD_DATA at each q2;
- drive ACK (0) after every byte except the last, and NACK (1) after the last.
REQ-027 SHALL, with BYTE_NUM=0, send the address only (probe) and then STOP.
REQ-028 SHALL clamp BYTE_NUM greater than MAX_BYTES to MAX_BYTES.
REQ-029 SHALL generate STOP as SDA=0 with SCL low, then SCL high, then SDA high, one quarter-phase per step.
REQ-030 SHALL, in DONE, set END_OK=1, set ACK_OK=!NACK_ERR, and enter REARM.
REQ-031 SHALL remain in REARM until GO=0, then return to IDLE; GO held high SHALL NOT retrigger.
REQ-032 SHALL update RD_DATA only during read bytes and leave it unchanged otherwise.
REQ-033 SHALL ignore GO, RW, SLAVE_ADDRESS, BYTE_NUM and WR_DATA changes while not in IDLE.

Reset
REQ-034 SHALL, while RESET_N=0 at a clock edge, set:
- SDAO=1, SCLO=1, END_OK=1;
- ACK_OK=0, NACK_ERR=0, RD_DATA=0;
- state IDLE, divider counter 0.
REQ-035 SHALL, on reset mid-transaction, release both lines on the next edge without generating a STOP.

Configuration
REQ-036 SHALL support macro I2C_CLK_STRETCH_EN.
- Defined: when SCLO=1 and SCLI=0, the quarter-phase counter freezes until SCLI=1.
- Undefined: SCLI is ignored and timing is purely CLK_DIV-based.

Structure
REQ-037 SHALL take from shared package i2c_pkg:
- the state enumeration and its 4-bit codes;
- the ACK/NACK bit constants;
- the byte-count width function.
REQ-038 SHALL instantiate sub-module i2c_tick_gen for quarter-phase tick generation, including the stretch freeze.

Verification
REQ-039 SHALL cover these directed scenarios:
- Write: addr 0x39, BYTE_NUM=2, WR_DATA[31:16]=0xA55A, slave ACKs all -> wire bytes 0x72, 0xA5, 0x5A; ACK_OK=1; NACK_ERR=0; END_OK rises after STOP.
- Read: addr 0x50, RW=1, BYTE_NUM=3, slave returns 0x12, 0x34, 0x56 -> first address byte 0xA1; RD_DATA[31:8]=0x123456; master ACK, ACK, NACK.
- NACK on address, BYTE_NUM=4 -> no data bytes sent; STOP follows; NACK_ERR=1; ACK_OK=0.
- Probe, BYTE_NUM=0 -> START, address, ACK, STOP only; GO held high after END_OK causes no second transaction.
- Stretch (macro defined): slave holds SCLI=0 for 50 clocks in bit 3 -> q2/q3 extended by 50 clocks; data intact. Macro undefined -> timing unchanged.
- RESET_N=0 during data byte 1 -> SDAO=SCLO=1 and END_OK=1 next edge; a new GO runs a clean transaction.
